// File: rtl/daylight_filter.sv
// Photo-sensor conditioner: synchroniser, tick prescaler, saturating integrator
// and INIT/DAY/NIGHT hysteresis FSM. Define DAYLIGHT_FILTER_HOLDOFF_EN to add a transition holdoff.
module daylight_filter #(
  parameter int TICK_DIV   = 50000,
  parameter int CNT_MAX    = 255,
  parameter int HI_TH      = 192,
  parameter int LO_TH      = 64,
  parameter int HOLD_TICKS = 1000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic DAYLIGHT_RAW,
  output logic DAYLIGHT,
  output logic DAYLIGHT_CHG,
  output logic DAYLIGHT_VALID
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_INIT  = CW'((HI_TH + LO_TH) / 2);
  localparam logic [CW-1:0] HI_V      = CW'(HI_TH);
  localparam logic [CW-1:0] LO_V      = CW'(LO_TH);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || LO_TH <= 0 || LO_TH >= HI_TH || HI_TH > CNT_MAX || HOLD_TICKS < 0) begin : g_bad_param
    $error("daylight_filter: illegal parameter combination");
  end

  typedef enum logic [1:0] {ST_INIT, ST_DAY, ST_NIGHT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync_q;
  logic          s_raw;
  logic [PW-1:0] presc;
  logic          tick;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          hold_ok;
  logic          chg_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= {sync_q[0], DAYLIGHT_RAW};
  end

  assign s_raw = sync_q[1];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)               presc <= '0;
    else if (presc == TICK_LAST) presc <= '0;
    else                         presc <= presc + PW'(1);
  end

  assign tick = (presc == TICK_LAST);

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_nxt = cnt;
    if (tick) begin
      if (s_raw) begin
        if (cnt != CNT_TOP) cnt_nxt = cnt + CW'(1);
      end else if (cnt != '0) begin
        cnt_nxt = cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) cnt <= CNT_INIT;
    else          cnt <= cnt_nxt;
  end

`ifdef DAYLIGHT_FILTER_HOLDOFF_EN
  localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_V = HW'(HOLD_TICKS);

  logic [HW-1:0] hold, hold_nxt;

  // A transition is allowed on the tick that brings the counter to zero.
  assign hold_ok = (hold <= HW'(1));

  always_comb begin
    hold_nxt = hold;
    if (tick && hold != '0) hold_nxt = hold - HW'(1);
    if (state_nxt != state && state_nxt != ST_INIT) hold_nxt = HOLD_V;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) hold <= '0;
    else          hold <= hold_nxt;
  end
`else
  assign hold_ok = 1'b1;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // Thresholds are judged against the post-tick integrator value so the state
  // flips on the same edge as the crossing update.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      unique case (state)
        ST_INIT: begin
          if (cnt_nxt >= HI_V)      state_nxt = ST_DAY;
          else if (cnt_nxt <= LO_V) state_nxt = ST_NIGHT;
        end
        ST_DAY:   if (hold_ok && cnt_nxt <= LO_V) state_nxt = ST_NIGHT;
        ST_NIGHT: if (hold_ok && cnt_nxt >= HI_V) state_nxt = ST_DAY;
        default:  state_nxt = ST_INIT;
      endcase
    end
  end

  // INIT->NIGHT leaves DAYLIGHT at 0, so it is not a toggle.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) chg_q <= 1'b0;
    else          chg_q <= (state_nxt == ST_DAY   && state != ST_DAY) ||
                           (state_nxt == ST_NIGHT && state == ST_DAY);
  end

  always_comb begin
    DAYLIGHT       = (state == ST_DAY);
    DAYLIGHT_VALID = (state != ST_INIT);
    DAYLIGHT_CHG   = chg_q;
  end

endmodule

// File: tb/tb_daylight_filter.sv
// Directed bench for daylight_filter with small parameters (TICK_DIV=4, CNT_MAX=15,
// HI_TH=12, LO_TH=4, HOLD_TICKS=20); honours DAYLIGHT_FILTER_HOLDOFF_EN.
module tb_daylight_filter;

  logic clk = 1'b0;
  logic rst_n;
  logic raw;
  logic day, chg, valid;

  int n_checks = 0;
  int n_fail   = 0;
  int chg_cnt;

  typedef struct {
    logic  raw;
    int    ticks;
    logic  exp_day;
    logic  exp_valid;
    logic  exp_chg_now;
    int    exp_chg_cnt;
    string name;
  } vec_t;

  vec_t vecs[11];

  daylight_filter #(
    .TICK_DIV(4), .CNT_MAX(15), .HI_TH(12), .LO_TH(4), .HOLD_TICKS(20)
  ) dut (
    .CLOCK_50      (clk),
    .RESET_N       (rst_n),
    .DAYLIGHT_RAW  (raw),
    .DAYLIGHT      (day),
    .DAYLIGHT_CHG  (chg),
    .DAYLIGHT_VALID(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_outs(input string name, input logic e_day, input logic e_valid, input logic e_chg);
    check({name, ".day"},   32'(day),   32'(e_day));
    check({name, ".valid"}, 32'(valid), 32'(e_valid));
    check({name, ".chg"},   32'(chg),   32'(e_chg));
  endtask

  // Starts #1 after a tick edge (or reset release) and ends #1 after the n-th tick edge.
  task automatic run_ticks(input int n);
    chg_cnt = 0;
    repeat (n * 4) begin
      @(posedge clk);
      #1;
      if (chg) chg_cnt++;
    end
  endtask

  task automatic pulse_reset(input string name);
    rst_n = 1'b0;
    #2;
    check_outs({name, ".async"}, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // raw, ticks, day, valid, chg_now, chg_cnt, name   (integrator after the step)
    vecs[0]  = '{1'b1,  3, 1'b0, 1'b0, 1'b0, 0, "pre_day"};        // 11
    vecs[1]  = '{1'b1,  1, 1'b1, 1'b1, 1'b1, 1, "first_day"};      // 12
    vecs[2]  = '{1'b1,  3, 1'b1, 1'b1, 1'b0, 0, "sat_hi"};         // 15
    vecs[3]  = '{1'b1,  5, 1'b1, 1'b1, 1'b0, 0, "sat_hold"};       // 15
    vecs[4]  = '{1'b0, 10, 1'b1, 1'b1, 1'b0, 0, "glitch_low"};     // 5
    vecs[5]  = '{1'b1, 10, 1'b1, 1'b1, 1'b0, 0, "glitch_recover"}; // 15
    vecs[6]  = '{1'b0, 10, 1'b1, 1'b1, 1'b0, 0, "band_low_edge"};  // 5
    vecs[7]  = '{1'b0,  1, 1'b0, 1'b1, 1'b1, 1, "to_night"};       // 4
    vecs[8]  = '{1'b0,  5, 1'b0, 1'b1, 1'b0, 0, "sat_lo"};         // 0
    vecs[9]  = '{1'b1, 11, 1'b0, 1'b1, 1'b0, 0, "band_high_edge"}; // 11
    vecs[10] = '{1'b0, 11, 1'b0, 1'b1, 1'b0, 0, "back_to_zero"};   // 0

    rst_n = 1'b0;
    raw   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      raw = vecs[i].raw;
      run_ticks(vecs[i].ticks);
      check_outs(vecs[i].name, vecs[i].exp_day, vecs[i].exp_valid, vecs[i].exp_chg_now);
      check({vecs[i].name, ".chg_cnt"}, 32'(chg_cnt), 32'(vecs[i].exp_chg_cnt));
    end

    // Long steady light, then dark: flip lands on exactly the 11th tick.
    raw = 1'b1;
    run_ticks(100);
    check_outs("sat_day", 1'b1, 1'b1, 1'b0);
    check("sat_day.chg_cnt", 32'(chg_cnt), 32'd1);
    raw = 1'b0;
    run_ticks(10);
    check_outs("flip_tick10", 1'b1, 1'b1, 1'b0);
    check("flip_tick10.chg_cnt", 32'(chg_cnt), 32'd0);
    run_ticks(1);
    check_outs("flip_tick11", 1'b0, 1'b1, 1'b1);

    // Just entered NIGHT at integrator 4: light returns immediately.
    raw = 1'b1;
`ifdef DAYLIGHT_FILTER_HOLDOFF_EN
    run_ticks(19);
    check_outs("holdoff_t19", 1'b0, 1'b1, 1'b0);
    check("holdoff_t19.chg_cnt", 32'(chg_cnt), 32'd0);
    run_ticks(1);
    check_outs("holdoff_t20", 1'b1, 1'b1, 1'b1);
`else
    run_ticks(7);
    check_outs("reday_t7", 1'b0, 1'b1, 1'b0);
    check("reday_t7.chg_cnt", 32'(chg_cnt), 32'd0);
    run_ticks(1);
    check_outs("reday_t8", 1'b1, 1'b1, 1'b1);
`endif

    // Reset while in DAY (CHG still high from the flip just sampled).
    pulse_reset("mid_reset");
    check_outs("mid_reset.release", 1'b0, 1'b0, 1'b0);
    run_ticks(3);
    check_outs("mid_reset.t3", 1'b0, 1'b0, 1'b0);
    check("mid_reset.t3.chg_cnt", 32'(chg_cnt), 32'd0);
    run_ticks(1);
    check_outs("mid_reset.t4", 1'b1, 1'b1, 1'b1);

    // Power-up into night.
    raw = 1'b0;
    pulse_reset("night_reset");
    check_outs("night_reset.release", 1'b0, 1'b0, 1'b0);
    run_ticks(3);
    check_outs("night.t3", 1'b0, 1'b0, 1'b0);
    check("night.t3.chg_cnt", 32'(chg_cnt), 32'd0);
    run_ticks(1);
    check_outs("night.t4", 1'b0, 1'b1, 1'b0);
    check("night.t4.chg_cnt", 32'(chg_cnt), 32'd0);
    run_ticks(5);
    check_outs("night.steady", 1'b0, 1'b1, 1'b0);
    check("night.steady.chg_cnt", 32'(chg_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
